// File: rtl/regfile_dual_wb_pkg.sv
// Shared types for the dual-write-port register file: operand, decode and
// retire payloads plus the register address type.
package regfile_dual_wb_pkg;

  localparam int REG_COUNT = 32;
  localparam int XLEN      = 32;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  // Operand payload consumed by EX: A = rs1 value, B = rs2 value.
  typedef struct packed {
    xword_t A;
    xword_t B;
  } regs_per_t;

  // one = lane A operands, two = lane B operands.
  typedef struct packed {
    regs_per_t one;
    regs_per_t two;
  } regs_t;

  // One decoded lane (64 bits); only rs1/rs2 matter to the register file.
  typedef struct packed {
    logic [31:0] pc;
    logic [16:0] cntrl;
    reg_addr_t   rd;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
  } id_lane_t;

  typedef struct packed {
    id_lane_t A;
    id_lane_t B;
  } id_ex_t;

  // One retiring lane from MEM/WB.
  typedef struct packed {
    logic [7:0] cntrl;
    reg_addr_t  rd;
    xword_t     data;
  } wb_lane_t;

  typedef struct packed {
    wb_lane_t A;
    wb_lane_t B;
  } mem_wb_t;

  // Architectural state for x1..x31; x0 has no storage.
  typedef logic [REG_COUNT-1:1][XLEN-1:0] reg_array_t;

  // A lane commits only when enabled and not targeting x0.
  function automatic logic lane_writes(input logic we, input reg_addr_t rd);
    return we && (rd != '0);
  endfunction

endpackage

// File: rtl/regfile_dual_wb_if.sv
// Bundle of the register file's pipeline-facing signals: decoded pair in,
// retiring pair in, operands and conflict flag out.
interface regfile_dual_wb_if;
  import regfile_dual_wb_pkg::*;

  id_ex_t     id_in;
  mem_wb_t    wb_in;
  logic [1:0] wb_we;
  regs_t      reg_out;
  logic       wb_conflict;

  // Pipeline side: drives decode and retire payloads, receives operands.
  modport master (
    output id_in,
    output wb_in,
    output wb_we,
    input  reg_out,
    input  wb_conflict
  );

  // Register file side.
  modport slave (
    input  id_in,
    input  wb_in,
    input  wb_we,
    output reg_out,
    output wb_conflict
  );

endinterface

// File: rtl/regfile_dual_wb_read_port.sv
// Single combinational read port: rs lookup, x0 forced to zero and, when
// REGFILE_WB_BYPASS_EN is defined, a write-first bypass from both
// retiring lanes (lane B has priority as the younger instruction).
module regfile_read_port
  import regfile_dual_wb_pkg::*;
(
  input  reg_array_t regs,
  input  reg_addr_t  rs,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic       wr_a,
  input  reg_addr_t  rd_a,
  input  xword_t     data_a,
  input  logic       wr_b,
  input  reg_addr_t  rd_b,
  input  xword_t     data_b,
`endif
  output xword_t     value
);

  // Select stored value, zero for x0, optionally overridden by a same-edge write.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    value = '0;
    if (rs != '0) begin
      value = regs[rs];
`ifdef REGFILE_WB_BYPASS_EN
      if (wr_a && (rd_a == rs)) value = data_a;
      if (wr_b && (rd_b == rs)) value = data_b;
`endif
    end
  end

endmodule

// File: rtl/regfile_dual_wb.sv
// Dual-write, quad-read integer register file for the dual-issue pipeline.
// Define REGFILE_WB_BYPASS_EN for write-first reads; otherwise same-edge
// reads return the pre-write value (read-first).
module regfile_dual_wb
  import regfile_dual_wb_pkg::*;
(
  input logic              clk,
  input logic              rst,
  regfile_dual_wb_if.slave bus
);

  reg_array_t regs_q, regs_d;
  regs_t      reg_out_q, reg_out_d;
  logic       wb_conflict_q, wb_conflict_d;

  logic       wr_a, wr_b;
  reg_addr_t  rs_addr [4];
  xword_t     rd_val  [4];

  assign wr_a = lane_writes(bus.wb_we[0], bus.wb_in.A.rd);
  assign wr_b = lane_writes(bus.wb_we[1], bus.wb_in.B.rd);

  assign rs_addr[0] = bus.id_in.A.rs1;
  assign rs_addr[1] = bus.id_in.A.rs2;
  assign rs_addr[2] = bus.id_in.B.rs1;
  assign rs_addr[3] = bus.id_in.B.rs2;

  for (genvar p = 0; p < 4; p++) begin : g_rd
    regfile_read_port u_port (
      .regs   (regs_q),
      .rs     (rs_addr[p]),
`ifdef REGFILE_WB_BYPASS_EN
      .wr_a   (wr_a),
      .rd_a   (bus.wb_in.A.rd),
      .data_a (bus.wb_in.A.data),
      .wr_b   (wr_b),
      .rd_b   (bus.wb_in.B.rd),
      .data_b (bus.wb_in.B.data),
`endif
      .value  (rd_val[p])
    );
  end

  // Next architectural state: lane A then lane B, so B wins a same-rd clash.
  always_comb begin
    regs_d = regs_q;
    if (wr_a) regs_d[bus.wb_in.A.rd] = bus.wb_in.A.data;
    if (wr_b) regs_d[bus.wb_in.B.rd] = bus.wb_in.B.data;
  end

  // Next operand payload and same-rd conflict flag.
  always_comb begin
    reg_out_d.one.A = rd_val[0];
    reg_out_d.one.B = rd_val[1];
    reg_out_d.two.A = rd_val[2];
    reg_out_d.two.B = rd_val[3];
    wb_conflict_d   = wr_a && wr_b && (bus.wb_in.A.rd == bus.wb_in.B.rd);
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage array is reset on purpose: software relies on all registers reading 0 after reset.
      regs_q        <= '0;
      reg_out_q     <= '0;
      wb_conflict_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      regs_q        <= regs_d;
      reg_out_q     <= reg_out_d;
      wb_conflict_q <= wb_conflict_d;
    end
  end

  assign bus.reg_out     = reg_out_q;
  assign bus.wb_conflict = wb_conflict_q;

  // Payload fields carried through the pipeline but not needed here.
  logic unused_fields;
  assign unused_fields = ^{bus.id_in.A.pc, bus.id_in.A.cntrl, bus.id_in.A.rd,
                           bus.id_in.B.pc, bus.id_in.B.cntrl, bus.id_in.B.rd,
                           bus.wb_in.A.cntrl, bus.wb_in.B.cntrl};

endmodule

// File: tb/tb_regfile_dual_wb.sv
// Self-checking bench for regfile_dual_wb: directed scenarios followed by
// random traffic against an array model. Honours REGFILE_WB_BYPASS_EN.
module tb_regfile_dual_wb;
  import regfile_dual_wb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_dual_wb_if bus ();

  regfile_dual_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     tests = 0;
  int     fails = 0;
  xword_t mdl [REG_COUNT];
  regs_t  exp_out;
  logic   exp_conf;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic xword_t rd_arch(input xword_t arr [REG_COUNT], input reg_addr_t a);
    return (a == '0) ? '0 : arr[a];
  endfunction

  // Present one cycle of inputs, advance one edge, update the model and check.
  task automatic cycle(input reg_addr_t a1, input reg_addr_t a2,
                       input reg_addr_t b1, input reg_addr_t b2,
                       input logic [1:0] we,
                       input reg_addr_t rda, input xword_t da,
                       input reg_addr_t rdb, input xword_t db);
    xword_t pre [REG_COUNT];
    bus.id_in        = '0;
    bus.id_in.A.rs1  = a1;
    bus.id_in.A.rs2  = a2;
    bus.id_in.B.rs1  = b1;
    bus.id_in.B.rs2  = b2;
    bus.wb_in        = '0;
    bus.wb_in.A.rd   = rda;
    bus.wb_in.A.data = da;
    bus.wb_in.B.rd   = rdb;
    bus.wb_in.B.data = db;
    bus.wb_we        = we;
    @(posedge clk);
    pre = mdl;
    if (we[0] && rda != 0) mdl[rda] = da;
    if (we[1] && rdb != 0) mdl[rdb] = db;
    exp_conf = (we == 2'b11) && (rda == rdb) && (rda != 0);
`ifdef REGFILE_WB_BYPASS_EN
    exp_out = {rd_arch(mdl, a1), rd_arch(mdl, a2), rd_arch(mdl, b1), rd_arch(mdl, b2)};
`else
    exp_out = {rd_arch(pre, a1), rd_arch(pre, a2), rd_arch(pre, b1), rd_arch(pre, b2)};
`endif
    #1;
    check("reg_out", bus.reg_out, exp_out);
    check("wb_conflict", bus.wb_conflict, exp_conf);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    rst       = 1'b1;
    bus.id_in = '0;
    bus.wb_in = '0;
    bus.wb_we = 2'b00;

    // Reset state.
    #8;
    check("reset_reg_out", bus.reg_out, 128'h0);
    check("reset_conflict", bus.wb_conflict, 1'b0);
    #4 rst = 1'b0;

    // x0 protection.
    cycle(0, 0, 0, 0, 2'b01, 0, 32'h1234_5678, 0, 32'h0);
    cycle(0, 0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0);
    check("x0_one_A", bus.reg_out.one.A, 32'h0);
    check("x0_conflict", bus.wb_conflict, 1'b0);

    // Dual write, distinct rd.
    cycle(0, 0, 0, 0, 2'b11, 3, 32'h0000_0011, 4, 32'h0000_0022);
    cycle(3, 4, 4, 3, 2'b00, 0, 32'h0, 0, 32'h0);
    check("dual_write", bus.reg_out, {32'h11, 32'h22, 32'h22, 32'h11});

    // Same-rd conflict: lane B wins, flag for exactly one cycle.
    cycle(0, 0, 0, 0, 2'b11, 7, 32'hAAAA_AAAA, 7, 32'hBBBB_BBBB);
    check("conflict_pulse", bus.wb_conflict, 1'b1);
    cycle(7, 7, 7, 7, 2'b00, 0, 32'h0, 0, 32'h0);
    check("conflict_value", bus.reg_out, {4{32'hBBBB_BBBB}});
    check("conflict_drop", bus.wb_conflict, 1'b0);

    // Same-edge read/write collision on x9.
    cycle(0, 0, 0, 0, 2'b01, 9, 32'h1, 0, 32'h0);
    cycle(0, 0, 0, 9, 2'b01, 9, 32'h2, 0, 32'h0);
`ifdef REGFILE_WB_BYPASS_EN
    check("collision_two_B", bus.reg_out.two.B, 32'h2);
`else
    check("collision_two_B", bus.reg_out.two.B, 32'h1);
`endif
    cycle(0, 0, 0, 9, 2'b00, 0, 32'h0, 0, 32'h0);
    check("collision_after", bus.reg_out.two.B, 32'h2);

    // Write-enable gating.
    cycle(0, 0, 0, 0, 2'b00, 10, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF);
    cycle(10, 0, 0, 0, 2'b00, 0, 32'h0, 0, 32'h0);
    check("we_gating", bus.reg_out.one.A, 32'h0);

    // Asynchronous reset mid-operation.
    cycle(0, 0, 0, 0, 2'b01, 5, 32'hDEAD_BEEF, 0, 32'h0);
    cycle(5, 5, 5, 5, 2'b00, 0, 32'h0, 0, 32'h0);
    check("pre_reset_x5", bus.reg_out.one.A, 32'hDEAD_BEEF);
    #3 rst = 1'b1;
    #1;
    check("async_reset_out", bus.reg_out, 128'h0);
    check("async_reset_conf", bus.wb_conflict, 1'b0);
    foreach (mdl[i]) mdl[i] = '0;
    #2 rst = 1'b0;
    cycle(5, 5, 5, 5, 2'b00, 0, 32'h0, 0, 32'h0);
    check("post_reset_x5", bus.reg_out.one.A, 32'h0);

    // Random traffic; narrow address range first to force collisions.
    for (int i = 0; i < 400; i++) begin
      int hi;
      hi = (i < 200) ? 7 : 31;
      cycle(5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)),
            5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)),
            2'($urandom_range(0, 3)),
            5'($urandom_range(0, hi)), $urandom,
            5'($urandom_range(0, hi)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dual_wb.md
# regfile_dual_wb

Dual-write-port, quad-read-port integer register file for the dual-issue pipeline. Accepts both retiring lanes from the MEM/WB register (`mem_wb_t`) plus per-lane write enables, and sources both ID-stage operands of both lanes (`regs_t`) from the rs1/rs2 fields of the decoded pair (`id_ex_t`). It is the writer-side endpoint of the MEM/WB payload and the producer of the operand payload consumed by EX.

## Interface
- `REG_COUNT`, 32: architectural registers; index 0 is hardwired zero.
- `XLEN`, 32: register width; must match `regs_per_t` fields.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_in`  in  `$bits(id_ex_t)` (128)  decoded pair; only `A.rs1`, `A.rs2`, `B.rs1`, `B.rs2` are used.
- `wb_in`  in  `$bits(mem_wb_t)`  retiring pair; `A/B.rd` give the address, `A/B.data` the value.
- `wb_we`  in  2  bit 0 = lane A write, bit 1 = lane B write; decoded upstream from `cntrl`.
- `reg_out`  out  `$bits(regs_t)` (128)  `one.A`/`one.B` = lane A rs1/rs2 values, `two.A`/`two.B` = lane B rs1/rs2 values.
- `wb_conflict`  out  1  registered pulse: both lanes wrote the same nonzero rd on the previous edge.

## Operation
- Storage: 31 x XLEN flops for x1..x31. x0 has no storage.
- Write: on each rising `clk`, a lane writes `data` to `rd` when its `wb_we` bit is 1 and `rd != 0`. Writes to rd=0 are dropped silently.
- Same-rd conflict: when both lanes write the same nonzero rd, lane B wins. Lane B is younger in program order. `wb_conflict` is 1 for the following cycle; otherwise it is 0.
- Read: on each rising `clk`, all four rs addresses are sampled and the addressed values are registered into `reg_out`. A read of x0 always returns 0.
- No stall input. Upstream holds `id_in` during a stall, so `reg_out` keeps refreshing and absorbs writes that retire during the stall.
- Reset (`rst`=1, at any time, including mid-write): all storage, `reg_out` and `wb_conflict` go to 0 immediately. A write on the edge coincident with reset is lost. The first write is honoured on the first rising edge after `rst` deasserts.

## Timing
- Write latency: 1 edge. Data is in storage after the edge where `wb_we` is sampled.
- Read latency: 1 edge. `reg_out` reflects the addresses presented before edge N and is valid after edge N.
- Same-edge read/write to the same register: the result depends on the configuration (see below).
- Reset values: `reg_out` = 128'h0, `wb_conflict` = 0, all registers 0.

## Configuration
- `REGFILE_WB_BYPASS_EN` defined (write-first): the same-edge read/write behaviour is set by an internal bypass mux per read port.
  - A read port whose rs matches a writing lane's nonzero rd takes that lane's `data`.
  - If both lanes match, lane B's `data` is taken.
- Undefined (read-first): `reg_out` on a same-edge collision returns the pre-write value. The EX forwarding unit must then cover a WB distance of 0.

## Structure
- Package additions to the shared struct/enum packages:
  - `REG_COUNT`.
  - `XLEN`.
  - `reg_addr_t` (`logic [4:0]`) as a named type for rd/rs.
- `regs_t`, `regs_per_t`, `id_ex_t` and `mem_wb_t` are reused unchanged.
- One natural sub-module, `regfile_read_port`: a single rs lookup, a zero test and the optional bypass mux. It is instantiated four times.

## Test plan
- Reset mid-operation: write x5=32'hDEAD_BEEF, then assert `rst` asynchronously between edges.
  - `reg_out` goes to 0 at once.
  - A read of x5 after release returns 0.
- x0 protection: lane A writes rd=0, data=32'h1234_5678, `wb_we`=2'b01; next cycle read rs1A=0.
  - `one.A` = 0.
  - `wb_conflict` = 0.
- Dual write, distinct rd: A writes x3=32'h0000_0011, B writes x4=32'h0000_0022.
  - Next cycle, lane A reads (3,4) and lane B reads (4,3).
  - `one` = {11, 22} and `two` = {22, 11}.
- Same-rd conflict: A writes x7=32'hAAAA_AAAA, B writes x7=32'hBBBB_BBBB.
  - A subsequent read of x7 = 32'hBBBB_BBBB on all four ports.
  - `wb_conflict` = 1 for exactly one cycle.
- Same-edge collision: x9 holds 32'h1; on one edge A writes x9=32'h2 while rs2B=9.
  - With `REGFILE_WB_BYPASS_EN`: `two.B` = 32'h2.
  - Without it: `two.B` = 32'h1, and 32'h2 appears on the next edge.
- Write enable gating: `wb_we`=2'b00 with rd=10, data=32'hFFFF_FFFF.
  - x10 keeps its prior value (0 after reset).
